// File: rtl/csr_scheduler_if.sv
// csr_scheduler_if: request and response channels between client logic and
// the csr_scheduler. Two requester valid/ready channels carry operands in and
// one valid/ready channel carries the complemented result and owner ID out.
// The master side is the client/consumer; the slave side is the scheduler.
interface csr_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/csr_scheduler.sv
// csr_scheduler: shares one external serial two's-complement shift-register
// datapath between two requesters. Accepts an operand, strobes the datapath
// load for one cycle, waits LAT cycles for the serial complement to settle,
// captures the datapath output and returns it with the requester ID.
//
// Optional feature: define CSR_SCHED_RR_EN for round-robin arbitration between
// the two requesters; otherwise requester 0 has fixed priority.
module csr_scheduler #(
    parameter int WIDTH = 4,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             set,
    csr_scheduler_if.slave   bus,
    output logic             csr_set,
    output logic [WIDTH-1:0] csr_din,
    input  logic [WIDTH-1:0] csr_dout,
    output logic             busy
);

    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] res;
    logic             id;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             cnt_last;

`ifdef CSR_SCHED_RR_EN
    logic rr_ptr;

    // Round-robin choice: the pointer breaks ties, a lone requester always wins
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = !rr_ptr;
            grant1 = rr_ptr;
        end
    end

    // Pointer moves to the requester that did not win, so it gets the next tie
    always_ff @(posedge clk) begin
        if (set) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant0;
        end
    end
`else
    // Fixed priority: requester 0 always wins a tie
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
    end
`endif

    assign cnt_last = (cnt == CNT_LAST);

    // Readies only in IDLE and never while reset is asserted, so reset beats a handshake
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        accept         = 1'b0;
        if (state == IDLE && !set) begin
            bus.req0_ready = grant0;
            bus.req1_ready = grant1;
            accept         = grant0 || grant1;
        end
    end

    // State register; reset drops any job in flight and returns to IDLE
    always_ff @(posedge clk) begin
        if (set) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the load / settle / respond sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)          state_next = LOAD;
            LOAD:                      state_next = RUN;
            RUN:  if (cnt_last)        state_next = DONE;
            DONE: if (bus.rsp_ready)   state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Operand/ID capture on accept, settle counter and result capture during RUN
    always_ff @(posedge clk) begin
        if (set) begin
            op  <= '0;
            id  <= 1'b0;
            res <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                op <= grant1 ? bus.req1_data : bus.req0_data;
                id <= grant1;
            end
            if (state == RUN) begin
                if (cnt_last) begin
                    cnt <= '0;
                    res <= csr_dout;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign csr_set      = set || (state == LOAD);
    assign csr_din      = op;
    assign busy         = (state != IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = res;
    assign bus.rsp_id    = id;

endmodule

// File: doc/csr_scheduler.md
# csr_scheduler

Controller that shares one serial two's-complement shift-register datapath (`complimentshiftreg`-style: `set`/load, parallel in, parallel out) between two requesters. It arbitrates incoming operands, pulses the datapath's load, waits a fixed LAT cycles for the serial complement to settle, captures the result and returns it with the requester ID over a valid/ready response channel. It sits between client logic and the datapath instance, which is external to this block.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; matches datapath width.
- `LAT`, 4, cycles from the end of the load cycle to a valid `csr_dout`. Legal range ≥ 1.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `set`  in  1  reset, synchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operand.
- `req0_data`  in  WIDTH  requester 0 operand.
- `req0_ready`  out  1  requester 0 accepted this cycle when high with valid.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_data`  out  WIDTH  two's complement of the granted operand, as returned by the datapath.
- `rsp_id`  out  1  requester that owns `rsp_data`.
- `rsp_ready`  in  1  consumer takes the result.
- `csr_set`  out  1  datapath set/load strobe.
- `csr_din`  out  WIDTH  datapath parallel input.
- `csr_dout`  in  WIDTH  datapath parallel output.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on a request handshake.
  - LOAD → RUN, always, after one cycle.
  - RUN → DONE when the cycle counter reaches LAT-1.
  - DONE → IDLE on the response handshake.
- IDLE:
  - `reqN_ready` is combinational and high only for the requester selected by the arbiter this cycle, among those with valid high.
  - On `valid && ready`, register the operand into `op` and the ID into `id`, then go to LOAD.
- LOAD:
  - `csr_set` = 1 for exactly one cycle.
  - `csr_din` = `op`.
- RUN:
  - Counter runs 0..LAT-1, one step per cycle.
  - `csr_din` holds `op` stable.
  - In the cycle where the counter equals LAT-1, `csr_dout` is registered into `res`.
- DONE:
  - `rsp_valid` = 1; `rsp_data` = `res`; `rsp_id` = `id`.
  - `rsp_valid` does not depend on `rsp_ready`.
  - On `rsp_valid && rsp_ready`, return to IDLE.
- Requests arriving outside IDLE are not accepted: both `reqN_ready` stay low. Requesters must hold valid and data until accepted.
- Counter width is $clog2(LAT+1). All operand and result registers are WIDTH bits. The block performs no arithmetic on the data.
- `csr_set` = `set` OR (state == LOAD), so the datapath is initialised whenever this block is reset.
- Arbitration is selected by the Configuration macro.

## Timing
- Reset values, in the cycle after `set` is sampled high:
  - State IDLE.
  - `rsp_valid`, `rsp_data`, `rsp_id`, `busy`, `csr_din` = 0.
  - Counter = 0; round-robin pointer = 0.
  - `csr_set` = 1 while `set` is high.
- Latency: for an accept at the clock edge ending cycle c:
  - LOAD is cycle c+1.
  - RUN is cycles c+2 .. c+LAT+1.
  - `rsp_valid` first goes high in cycle c+LAT+2.
- Minimum job period is LAT+3 cycles, with `rsp_ready` tied high.
- While stalled in DONE, `rsp_data` and `rsp_id` are stable and no new request is granted.
- Reset mid-operation (LOAD/RUN/DONE):
  - The job is dropped.
  - FSM goes to IDLE next cycle.
  - No response is issued for the dropped job.
- A request handshake and `set` high in the same cycle: `set` wins and the request is not accepted.

## Configuration
- `CSR_SCHED_RR_EN` defined: round-robin.
  - The pointer names the preferred requester.
  - When both are valid, the pointer's requester wins.
  - On each grant, the pointer moves to the other requester.
  - With a single valid requester, that requester is granted regardless of the pointer.
- Not defined: fixed priority, requester 0 always wins. The pointer logic is absent.

## Test plan
1. Reset: hold `set` 2 cycles with both requesters valid → `csr_set`=1 in both cycles, all other outputs 0, no ready. After release, `req0_ready`=1 in the next cycle.
2. Single job: `req0_data`=4'b1010, datapath model returns 0110 after LAT=4 → `csr_set` pulses once with `csr_din`=1010; `rsp_valid` in cycle c+6 with `rsp_data`=0110, `rsp_id`=0; `busy` high c+1..c+6.
3. Contention: both valid (req0=0101, req1=0011) and held.
   - With `CSR_SCHED_RR_EN`: responses in order id0/1011, then id1/1101.
   - Without it: the second grant also goes to requester 0 while req0 stays valid.
4. Backpressure: `rsp_ready` low for 5 cycles in DONE → `rsp_valid`, `rsp_data`, `rsp_id` stable, both readies low, `csr_set` stays 0.
5. Reset mid-RUN: assert `set` at counter=2 → next cycle IDLE and `busy`=0; no response for that job. A following job with 0001 returns 1111.
6. Edge operands: 0000 → 0000; 1000 → 1000; LAT=1 build → `rsp_valid` in cycle c+3.
